// File: rtl/nios_system_pio_in_edge_pkg.sv
// Shared constants for the debounced edge-capture PIO: register offsets,
// edge-mode encodings and Avalon bus widths.
package nios_pio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_system_pio_in_edge_if.sv
// Avalon-MM slave port of the PIO: word address, select, write strobe and data.
interface nios_system_pio_in_edge_if;
  import nios_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/nios_system_pio_in_edge_debounce.sv
// One input bit: 2-flop synchroniser, persistence filter and flip events.
// With DEBOUNCE_CYCLES=0 the synchroniser output is used directly.
module pio_debounce_bit
  import nios_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable,
  output logic rise_c,
  output logic fall_c
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    logic prev;

    always_ff @(posedge clk) begin
      if (reset) prev <= 1'b0;
      else       prev <= sync2;
    end

    assign stable = sync2;
    assign rise_c = sync2 & ~prev;
    assign fall_c = ~sync2 & prev;
  end else begin : g_filter
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             accept_c;

    // Flip on the edge that completes the required run of mismatches.
    assign accept_c = (sync2 != level) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (sync2 == level) begin
        cnt <= '0;
      end else if (accept_c) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign stable = level;
    assign rise_c = accept_c & sync2;
    assign fall_c = accept_c & ~sync2;
  end

endmodule

// File: rtl/nios_system_pio_in_edge.sv
// Debounced N-bit input PIO with sticky edge capture and maskable level irq,
// exposed as a 4-register Avalon-MM slave.
module nios_system_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_MODE       = EDGE_RISE
) (
  input  logic                       clk,
  input  logic                       reset,
  nios_system_pio_in_edge_if.slave   avs,
  input  logic [WIDTH-1:0]           in_port,
  output logic                       irq
);

  logic [WIDTH-1:0]  stable;
  logic [WIDTH-1:0]  rise_c;
  logic [WIDTH-1:0]  fall_c;
  logic [WIDTH-1:0]  event_c;
  logic [WIDTH-1:0]  clear_c;
  logic [WIDTH-1:0]  interruptmask;
  logic [WIDTH-1:0]  edgecapture;
  logic [DATA_W-1:0] rdata_c;
  logic              wr_c;
  logic              unused_wdata_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .in_bit (in_port[i]),
      .stable (stable[i]),
      .rise_c (rise_c[i]),
      .fall_c (fall_c[i])
    );
  end

  always_comb begin
    event_c = rise_c;
    if (EDGE_MODE == EDGE_FALL)     event_c = fall_c;
    else if (EDGE_MODE == EDGE_ANY) event_c = rise_c | fall_c;
  end

  assign wr_c           = avs.chipselect & ~avs.write_n;
  assign clear_c        = (wr_c && avs.address == ADDR_EDGE) ? avs.writedata[WIDTH-1:0] : '0;
  assign unused_wdata_c = ^avs.writedata;

  // Read mux: bits above WIDTH-1 and the reserved word read as zero.
  always_comb begin
    rdata_c = '0;
    case (avs.address)
      ADDR_DATA: rdata_c[WIDTH-1:0] = stable;
      ADDR_MASK: rdata_c[WIDTH-1:0] = interruptmask;
      ADDR_EDGE: rdata_c[WIDTH-1:0] = edgecapture;
      default:   rdata_c = '0;
    endcase
  end

  // A new event on a bit overrides a same-cycle write-1-clear of that bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      interruptmask <= '0;
      edgecapture   <= '0;
      avs.readdata  <= '0;
      irq           <= 1'b0;
    end else begin
      if (wr_c && avs.address == ADDR_MASK) interruptmask <= avs.writedata[WIDTH-1:0];
      edgecapture  <= (edgecapture & ~clear_c) | event_c;
      avs.readdata <= rdata_c;
      irq          <= |(edgecapture & interruptmask);
    end
  end

endmodule

// File: tb/tb_nios_system_pio_in_edge.sv
// Bench for nios_system_pio_in_edge: directed sequences, a vector table and
// randomized traffic against a behavioural model.
module tb_nios_system_pio_in_edge;
  import nios_pio_pkg::*;

  localparam int unsigned A_DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_a = '0;
  logic [3:0] in_c = '0;
  logic [7:0] in_b = '0;
  logic       irq_a, irq_b, irq_c;

  always #5 clk = ~clk;

  nios_system_pio_in_edge_if ifa ();
  nios_system_pio_in_edge_if ifb ();
  nios_system_pio_in_edge_if ifc ();

  nios_system_pio_in_edge #(.WIDTH(4), .DEBOUNCE_CYCLES(A_DB), .EDGE_MODE(EDGE_RISE)) dut_a (
    .clk(clk), .reset(reset), .avs(ifa), .in_port(in_a), .irq(irq_a));
  nios_system_pio_in_edge #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE(EDGE_ANY)) dut_b (
    .clk(clk), .reset(reset), .avs(ifb), .in_port(in_b), .irq(irq_b));
  nios_system_pio_in_edge dut_c (
    .clk(clk), .reset(reset), .avs(ifc), .in_port(in_c), .irq(irq_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Behavioural model for dut_a: a level is accepted once the synchronised
  // input has disagreed with it on each of the last A_DB edges.
  logic [3:0]  hist[$];
  logic [3:0]  m_s1, m_s2, m_stable, m_mask, m_ec, m_ev, m_nst, m_clr;
  logic [31:0] m_rd;
  logic        m_irq, m_all, m_wr;
  logic        mdl_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      hist.delete();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_mask = '0; m_ec = '0;
      m_rd = '0; m_irq = 1'b0;
    end else begin
      case (ifa.address)
        ADDR_DATA: m_rd = {28'b0, m_stable};
        ADDR_MASK: m_rd = {28'b0, m_mask};
        ADDR_EDGE: m_rd = {28'b0, m_ec};
        default:   m_rd = '0;
      endcase
      m_irq = |(m_ec & m_mask);
      hist.push_back(m_s2);
      if (hist.size() > A_DB) void'(hist.pop_front());
      m_nst = m_stable;
      m_ev  = '0;
      for (int b = 0; b < 4; b++) begin
        m_all = (hist.size() == A_DB);
        foreach (hist[k]) if (hist[k][b] == m_stable[b]) m_all = 1'b0;
        if (m_all) begin
          m_nst[b] = ~m_stable[b];
          if (!m_stable[b]) m_ev[b] = 1'b1;
        end
      end
      m_wr  = ifa.chipselect && !ifa.write_n;
      m_clr = (m_wr && ifa.address == ADDR_EDGE) ? ifa.writedata[3:0] : 4'b0;
      if (m_wr && ifa.address == ADDR_MASK) m_mask = ifa.writedata[3:0];
      m_ec     = (m_ec & ~m_clr) | m_ev;
      m_stable = m_nst;
      m_s2     = m_s1;
      m_s1     = in_a;
    end
  end

  always @(negedge clk) begin
    if (mdl_en) begin
      check("a_model_rd", ifa.readdata, m_rd);
      check("a_model_irq", 32'(irq_a), 32'(m_irq));
    end
  end

  task automatic wr_a(input logic [1:0] addr, input logic [31:0] data);
    ifa.chipselect = 1'b1; ifa.write_n = 1'b0; ifa.address = addr; ifa.writedata = data;
    @(negedge clk);
    ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
  endtask

  task automatic wr_c(input logic [1:0] addr, input logic [31:0] data);
    ifc.chipselect = 1'b1; ifc.write_n = 1'b0; ifc.address = addr; ifc.writedata = data;
    @(negedge clk);
    ifc.chipselect = 1'b0; ifc.write_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  vin;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [12];
  int   hold [4];
  int   r;

  initial begin
    ifa.chipselect = 1'b0; ifa.write_n = 1'b1; ifa.address = '0; ifa.writedata = '0;
    ifb.chipselect = 1'b0; ifb.write_n = 1'b1; ifb.address = '0; ifb.writedata = '0;
    ifc.chipselect = 1'b0; ifc.write_n = 1'b1; ifc.address = '0; ifc.writedata = '0;

    // dut_b (8 bits, no debounce, any edge); each row is one clock
    tbl[0]  = '{8'h80, 2'd0, 1'b0, 32'h0,  32'h0,  1'b0};
    tbl[1]  = '{8'h80, 2'd0, 1'b0, 32'h0,  32'h0,  1'b0};
    tbl[2]  = '{8'h80, 2'd0, 1'b0, 32'h0,  32'h80, 1'b0};
    tbl[3]  = '{8'h00, 2'd3, 1'b0, 32'h0,  32'h80, 1'b0};
    tbl[4]  = '{8'h00, 2'd3, 1'b1, 32'h80, 32'h80, 1'b0};
    tbl[5]  = '{8'h00, 2'd3, 1'b0, 32'h0,  32'h0,  1'b0};
    tbl[6]  = '{8'h00, 2'd3, 1'b0, 32'h0,  32'h80, 1'b0};
    tbl[7]  = '{8'h00, 2'd0, 1'b0, 32'h0,  32'h0,  1'b0};
    tbl[8]  = '{8'h00, 2'd2, 1'b1, 32'h80, 32'h0,  1'b0};
    tbl[9]  = '{8'h00, 2'd2, 1'b0, 32'h0,  32'h80, 1'b1};
    tbl[10] = '{8'h00, 2'd3, 1'b1, 32'hFF, 32'h80, 1'b1};
    tbl[11] = '{8'h00, 2'd3, 1'b0, 32'h0,  32'h0,  1'b0};

    // dut_c: input held high through reset counts in after 2+16+1 edges
    in_c = 4'hF;
    repeat (2) @(negedge clk);
    check("c_reset_rd", ifc.readdata, 32'h0);
    check("c_reset_irq", 32'(irq_c), 32'h0);
    reset = 1'b0;
    mdl_en = 1'b1;
    repeat (18) @(negedge clk);
    check("c_data_e18", ifc.readdata, 32'h0);
    @(negedge clk);
    check("c_data_e19", ifc.readdata, 32'hF);
    wr_c(ADDR_MASK, 32'hF);
    ifc.address = ADDR_DATA;
    @(negedge clk);
    check("c_irq_set", 32'(irq_c), 32'h1);

    // reset in the middle of a debounce count
    in_c = 4'h0;
    repeat (8) @(negedge clk);
    in_c = 4'hF;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("c_midreset_rd", ifc.readdata, 32'h0);
    check("c_midreset_irq", 32'(irq_c), 32'h0);
    reset = 1'b0;
    repeat (18) @(negedge clk);
    check("c_rearm_e18", ifc.readdata, 32'h0);
    @(negedge clk);
    check("c_rearm_e19", ifc.readdata, 32'hF);

    // dut_a debounce latency
    ifa.address = ADDR_EDGE;
    in_a[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("a_lat_e6", ifa.readdata, 32'h0);
    @(negedge clk);
    check("a_lat_e7", ifa.readdata, 32'h1);
    wr_a(ADDR_EDGE, 32'h1);

    // glitch shorter than the window is rejected, and the count restarts
    ifa.address = ADDR_EDGE;
    in_a[1] = 1'b1;
    repeat (3) @(negedge clk);
    in_a[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("a_glitch_ec", ifa.readdata, 32'h0);
    ifa.address = ADDR_DATA;
    @(negedge clk);
    check("a_glitch_data", ifa.readdata, 32'h1);
    in_a[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("a_restart_e6", ifa.readdata, 32'h1);
    @(negedge clk);
    check("a_restart_e7", ifa.readdata, 32'h3);
    wr_a(ADDR_EDGE, 32'h2);

    // interrupt path
    wr_a(ADDR_MASK, 32'h4);
    ifa.address = ADDR_EDGE;
    in_a[2] = 1'b1;
    repeat (6) @(negedge clk);
    check("a_irq_e6", 32'(irq_a), 32'h0);
    @(negedge clk);
    check("a_irq_e7", 32'(irq_a), 32'h1);
    wr_a(ADDR_EDGE, 32'h4);
    check("a_irq_clr_edge", 32'(irq_a), 32'h1);
    @(negedge clk);
    check("a_irq_cleared", 32'(irq_a), 32'h0);
    in_a[3] = 1'b1;
    repeat (8) @(negedge clk);
    check("a_irq_unmasked_bit", 32'(irq_a), 32'h0);
    check("a_ec_bit3", ifa.readdata, 32'h8);

    // set beats clear on the same edge
    in_a[0] = 1'b0;
    repeat (8) @(negedge clk);
    in_a[0] = 1'b1;
    repeat (5) @(negedge clk);
    ifa.chipselect = 1'b1; ifa.write_n = 1'b0; ifa.address = ADDR_EDGE; ifa.writedata = 32'hF;
    @(negedge clk);
    ifa.chipselect = 1'b0; ifa.write_n = 1'b1;
    @(negedge clk);
    check("a_set_beats_clear", ifa.readdata, 32'h1);

    // unmasking a pending bit raises irq one edge after the write
    wr_a(ADDR_MASK, 32'h1);
    check("a_unmask_e0", 32'(irq_a), 32'h0);
    @(negedge clk);
    check("a_unmask_e1", 32'(irq_a), 32'h1);

    // randomized traffic on dut_a, checked by the model every cycle
    for (int b = 0; b < 4; b++) hold[b] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          in_a[b] = ~in_a[b];
          hold[b] = int'($urandom_range(1, 9));
        end else begin
          hold[b]--;
        end
      end
      r = int'($urandom_range(0, 9));
      ifa.address   = 2'($urandom_range(0, 3));
      ifa.writedata = $urandom;
      if (r < 2) begin
        ifa.chipselect = 1'b1; ifa.write_n = 1'b0;
      end else if (r == 2) begin
        ifa.chipselect = 1'b0; ifa.write_n = 1'b0;
      end else begin
        ifa.chipselect = 1'b1; ifa.write_n = 1'b1;
      end
      @(negedge clk);
    end
    ifa.chipselect = 1'b0; ifa.write_n = 1'b1;

    // dut_b vector table
    for (int i = 0; i < 12; i++) begin
      in_b           = tbl[i].vin;
      ifb.address    = tbl[i].addr;
      ifb.chipselect = 1'b1;
      ifb.write_n    = ~tbl[i].wr;
      ifb.writedata  = tbl[i].wdata;
      @(negedge clk);
      check($sformatf("b_rd_%0d", i), ifb.readdata, tbl[i].exp_rd);
      check($sformatf("b_irq_%0d", i), 32'(irq_b), 32'(tbl[i].exp_irq));
    end
    ifb.chipselect = 1'b0; ifb.write_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
